tlb_assoc: RTL and testbench

Parametrised set-associative TLB for the MMU, successor to the fixed 4-way/4-set translation buffer. It translates a 32-bit virtual address plus address-space ID (ASID) to a physical page number and MMU flags, with one-cycle registered read latency. It adds true per-set LRU replacement, ASID/global tagging, duplicate-free refill and selective invalidation. It sits between the load/store and fetch address paths and the page-table walker, which issues the refills.

---
 rtl/tlb_assoc.sv | 223 ++++++++++++++++++++++
 tb/tb_tlb_assoc.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_assoc.sv
// Set-associative TLB: ASID/global tagging, per-set LRU replacement, duplicate-free
// refill and selective invalidation, with a one-cycle registered lookup result.
module tlb_assoc #(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned SETS       = 4,
    parameter int unsigned PAGE_SHIFT = 14,
    parameter int unsigned ASID_W     = 8,
    parameter int unsigned FLAG_W     = 14,
    parameter int unsigned PA_W       = 32
) (
    input  logic                       iCLOCK,
    input  logic                       inRESET,
    input  logic                       iINV_REQ,
    input  logic [1:0]                 iINV_MODE,
    input  logic [31:0]                iINV_VADDR,
    input  logic [ASID_W-1:0]          iINV_ASID,
    input  logic                       iRD_REQ,
    input  logic [31:0]                iRD_VADDR,
    input  logic [ASID_W-1:0]          iRD_ASID,
    output logic                       oRD_VALID,
    output logic                       oRD_HIT,
    output logic [FLAG_W-1:0]          oRD_FLAGS,
    output logic [PA_W-1:0]            oRD_PADDR,
    input  logic                       iWR_REQ,
    input  logic [31:0]                iWR_VADDR,
    input  logic [ASID_W-1:0]          iWR_ASID,
    input  logic                       iWR_GLOBAL,
    input  logic [PA_W-PAGE_SHIFT-1:0] iWR_PPN,
    input  logic [FLAG_W-1:0]          iWR_FLAGS
);
    localparam int unsigned   IW      = $clog2(SETS);
    localparam int unsigned   AW      = $clog2(WAYS);
    localparam int unsigned   TAG_W   = 32 - PAGE_SHIFT - IW;
    localparam int unsigned   PPN_W   = PA_W - PAGE_SHIFT;
    localparam logic [AW-1:0] AGE_MAX = AW'(WAYS - 1);

    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [ASID_W-1:0] asid_q  [SETS][WAYS];
    logic              glb_q   [SETS][WAYS];
    logic [PPN_W-1:0]  ppn_q   [SETS][WAYS];
    logic [FLAG_W-1:0] flags_q [SETS][WAYS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   valid_d [SETS];
    logic [AW-1:0]     age_q   [SETS][WAYS];
    logic [AW-1:0]     age_d   [SETS][WAYS];

    logic              rd_valid_q;
    logic              rd_hit_q;
    logic [FLAG_W-1:0] rd_flags_q;
    logic [PA_W-1:0]   rd_paddr_q;

    logic [IW-1:0]     rd_idx;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_hit;
    logic [AW-1:0]     rd_way;
    logic              rd_touch;

    logic [IW-1:0]     wr_idx;
    logic [TAG_W-1:0]  wr_tag;
    logic              wr_match;
    logic [AW-1:0]     wr_match_way;
    logic              wr_free;
    logic [AW-1:0]     wr_free_way;
    logic [AW-1:0]     wr_victim;
    logic [AW-1:0]     wr_way;

    logic [IW-1:0]     inv_idx;
    logic [TAG_W-1:0]  inv_tag;

    assign rd_idx  = iRD_VADDR[PAGE_SHIFT +: IW];
    assign rd_tag  = iRD_VADDR[31 -: TAG_W];
    assign wr_idx  = iWR_VADDR[PAGE_SHIFT +: IW];
    assign wr_tag  = iWR_VADDR[31 -: TAG_W];
    assign inv_idx = iINV_VADDR[PAGE_SHIFT +: IW];
    assign inv_tag = iINV_VADDR[31 -: TAG_W];

    // Descending scans so the lowest qualifying way is the one left selected.
    always_comb begin
        rd_hit = 1'b0;
        rd_way = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_q[rd_idx][w] && tag_q[rd_idx][w] == rd_tag &&
                (glb_q[rd_idx][w] || asid_q[rd_idx][w] == iRD_ASID)) begin
                rd_hit = 1'b1;
                rd_way = AW'(w);
            end
        end
    end

    always_comb begin
        wr_match     = 1'b0;
        wr_match_way = '0;
        wr_free      = 1'b0;
        wr_free_way  = '0;
        wr_victim    = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_q[wr_idx][w] && tag_q[wr_idx][w] == wr_tag &&
                (glb_q[wr_idx][w] || asid_q[wr_idx][w] == iWR_ASID)) begin
                wr_match     = 1'b1;
                wr_match_way = AW'(w);
            end
            if (!valid_q[wr_idx][w]) begin
                wr_free     = 1'b1;
                wr_free_way = AW'(w);
            end
            if (age_q[wr_idx][w] == AGE_MAX) begin
                wr_victim = AW'(w);
            end
        end
        wr_way = wr_victim;
        if (wr_match) begin
            wr_way = wr_match_way;
        end else if (wr_free) begin
            wr_way = wr_free_way;
        end
    end

    assign rd_touch = iRD_REQ && rd_hit && !(iWR_REQ && wr_idx == rd_idx);

    always_comb begin
        logic          kill;
        logic [AW-1:0] ref_age;
        kill    = 1'b0;
        ref_age = AGE_MAX;
        valid_d = valid_q;
        age_d   = age_q;
        if (iINV_REQ) begin
            for (int s = 0; s < int'(SETS); s++) begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    case (iINV_MODE)
                        2'd0: kill = valid_q[s][w] && IW'(s) == inv_idx &&
                                     tag_q[s][w] == inv_tag &&
                                     (glb_q[s][w] || asid_q[s][w] == iINV_ASID);
                        2'd1: kill = valid_q[s][w] && !glb_q[s][w] &&
                                     asid_q[s][w] == iINV_ASID;
                        2'd2: kill = valid_q[s][w] && !glb_q[s][w];
                        default: kill = 1'b1;
                    endcase
                    if (kill) begin
                        valid_d[s][w] = 1'b0;
                        age_d[s][w]   = AGE_MAX;
                    end
                end
            end
        end else begin
            if (iWR_REQ) begin
                ref_age = valid_q[wr_idx][wr_way] ? age_q[wr_idx][wr_way] : AGE_MAX;
                for (int w = 0; w < int'(WAYS); w++) begin
                    if (AW'(w) == wr_way) begin
                        age_d[wr_idx][w] = '0;
                    end else if (valid_q[wr_idx][w] && age_q[wr_idx][w] < ref_age) begin
                        age_d[wr_idx][w] = age_q[wr_idx][w] + 1'b1;
                    end
                end
                valid_d[wr_idx][wr_way] = 1'b1;
            end
            // Read touch only lands in a set the refill leaves alone.
            if (rd_touch) begin
                ref_age = age_q[rd_idx][rd_way];
                for (int w = 0; w < int'(WAYS); w++) begin
                    if (AW'(w) == rd_way) begin
                        age_d[rd_idx][w] = '0;
                    end else if (valid_q[rd_idx][w] && age_q[rd_idx][w] < ref_age) begin
                        age_d[rd_idx][w] = age_q[rd_idx][w] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < int'(WAYS); w++) begin
                    age_q[s][w] <= AGE_MAX;
                end
            end
        end else begin
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= valid_d[s];
                for (int w = 0; w < int'(WAYS); w++) begin
                    age_q[s][w] <= age_d[s][w];
                end
            end
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iWR_REQ && !iINV_REQ) begin
            tag_q[wr_idx][wr_way]   <= wr_tag;
            asid_q[wr_idx][wr_way]  <= iWR_ASID;
            glb_q[wr_idx][wr_way]   <= iWR_GLOBAL;
            ppn_q[wr_idx][wr_way]   <= iWR_PPN;
            flags_q[wr_idx][wr_way] <= iWR_FLAGS;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_flags_q <= '0;
            rd_paddr_q <= '0;
        end else begin
            rd_valid_q <= iRD_REQ;
            rd_hit_q   <= iRD_REQ && rd_hit;
            if (iRD_REQ && rd_hit) begin
                rd_flags_q <= flags_q[rd_idx][rd_way];
                rd_paddr_q <= {ppn_q[rd_idx][rd_way], iRD_VADDR[PAGE_SHIFT-1:0]};
            end else begin
                rd_flags_q <= '0;
                rd_paddr_q <= '0;
            end
        end
    end

    assign oRD_VALID = rd_valid_q;
    assign oRD_HIT   = rd_hit_q;
    assign oRD_FLAGS = rd_flags_q;
    assign oRD_PADDR = rd_paddr_q;

endmodule

// File: tb/tb_tlb_assoc.sv
// Bench for tlb_assoc: directed vector table, then random traffic against an entry-level
// reference model, then an asynchronous reset while a result is being presented.
module tb_tlb_assoc;
    localparam int WAYS = 4;
    localparam int SETS = 4;
    localparam int PS   = 14;

    logic        iCLOCK = 1'b0;
    logic        inRESET = 1'b0;
    logic        iINV_REQ, iRD_REQ, iWR_REQ, iWR_GLOBAL;
    logic [1:0]  iINV_MODE;
    logic [31:0] iINV_VADDR, iRD_VADDR, iWR_VADDR;
    logic [7:0]  iINV_ASID, iRD_ASID, iWR_ASID;
    logic [17:0] iWR_PPN;
    logic [13:0] iWR_FLAGS;
    logic        oRD_VALID, oRD_HIT;
    logic [13:0] oRD_FLAGS;
    logic [31:0] oRD_PADDR;

    always #5 iCLOCK = ~iCLOCK;

    tlb_assoc #(
        .WAYS(4), .SETS(4), .PAGE_SHIFT(14), .ASID_W(8), .FLAG_W(14), .PA_W(32)
    ) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET),
        .iINV_REQ(iINV_REQ), .iINV_MODE(iINV_MODE), .iINV_VADDR(iINV_VADDR),
        .iINV_ASID(iINV_ASID),
        .iRD_REQ(iRD_REQ), .iRD_VADDR(iRD_VADDR), .iRD_ASID(iRD_ASID),
        .oRD_VALID(oRD_VALID), .oRD_HIT(oRD_HIT), .oRD_FLAGS(oRD_FLAGS),
        .oRD_PADDR(oRD_PADDR),
        .iWR_REQ(iWR_REQ), .iWR_VADDR(iWR_VADDR), .iWR_ASID(iWR_ASID),
        .iWR_GLOBAL(iWR_GLOBAL), .iWR_PPN(iWR_PPN), .iWR_FLAGS(iWR_FLAGS)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rd;  logic [31:0] rva; logic [7:0] ras;
        logic        wr;  logic [31:0] wva; logic [7:0] was; logic wg;
        logic [17:0] ppn; logic [13:0] wfl;
        logic        inv; logic [1:0]  im;  logic [31:0] iva; logic [7:0] ias;
        logic        ev;  logic        eh;  logic [13:0] ef;  logic [31:0] ep;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t v_rd(logic [31:0] va, logic [7:0] as, logic eh,
                                  logic [13:0] ef, logic [31:0] ep);
        vec_t v;
        v = '{default: '0};
        v.rd = 1'b1; v.rva = va; v.ras = as;
        v.ev = 1'b1; v.eh = eh; v.ef = ef; v.ep = ep;
        return v;
    endfunction

    function automatic vec_t v_wr(logic [31:0] va, logic [7:0] as, logic g,
                                  logic [17:0] ppn, logic [13:0] fl);
        vec_t v;
        v = '{default: '0};
        v.wr = 1'b1; v.wva = va; v.was = as; v.wg = g; v.ppn = ppn; v.wfl = fl;
        return v;
    endfunction

    function automatic vec_t v_inv(logic [1:0] m, logic [31:0] va, logic [7:0] as);
        vec_t v;
        v = '{default: '0};
        v.inv = 1'b1; v.im = m; v.iva = va; v.ias = as;
        return v;
    endfunction

    task automatic drive(vec_t v);
        iRD_REQ = v.rd;  iRD_VADDR = v.rva; iRD_ASID = v.ras;
        iWR_REQ = v.wr;  iWR_VADDR = v.wva; iWR_ASID = v.was; iWR_GLOBAL = v.wg;
        iWR_PPN = v.ppn; iWR_FLAGS = v.wfl;
        iINV_REQ = v.inv; iINV_MODE = v.im; iINV_VADDR = v.iva; iINV_ASID = v.ias;
    endtask

    task automatic idle();
        vec_t v;
        v = '{default: '0};
        drive(v);
    endtask

    task automatic check(string name, logic [47:0] act, logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got v/h/flags/paddr=%h required %h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] outs();
        return {oRD_VALID, oRD_HIT, oRD_FLAGS, oRD_PADDR};
    endfunction

    // Reference model: entries keyed by full virtual page number.
    typedef struct {
        bit v; int unsigned vpn; int unsigned asid; bit g;
        int unsigned ppn; int unsigned fl; int age;
    } ent_t;
    ent_t m [SETS][WAYS];

    task automatic m_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m[s][w].v = 1'b0;
                m[s][w].age = WAYS - 1;
            end
    endtask

    function automatic int m_find(int s, int unsigned vpn, int unsigned asid);
        for (int w = 0; w < WAYS; w++)
            if (m[s][w].v && m[s][w].vpn == vpn && (m[s][w].g || m[s][w].asid == asid))
                return w;
        return -1;
    endfunction

    task automatic m_touch(int s, int w);
        int r;
        r = m[s][w].v ? m[s][w].age : WAYS - 1;
        for (int k = 0; k < WAYS; k++)
            if (k != w && m[s][k].v && m[s][k].age < r) m[s][k].age++;
        m[s][w].age = 0;
    endtask

    task automatic m_step(output logic [47:0] exp);
        int unsigned rvpn, wvpn, ivpn;
        int rs, rw, ws, ww;
        bit kill;
        rvpn = iRD_VADDR >> PS;
        rs   = int'(rvpn % SETS);
        rw   = m_find(rs, rvpn, iRD_ASID);
        exp  = '0;
        if (iRD_REQ) begin
            if (rw >= 0)
                exp = {1'b1, 1'b1, 14'(m[rs][rw].fl),
                       32'((m[rs][rw].ppn << PS) | (iRD_VADDR & 32'h3FFF))};
            else
                exp = {1'b1, 47'h0};
        end
        if (iINV_REQ) begin
            ivpn = iINV_VADDR >> PS;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    case (iINV_MODE)
                        2'd0: kill = m[s][w].v && m[s][w].vpn == ivpn &&
                                     (m[s][w].g || m[s][w].asid == iINV_ASID);
                        2'd1: kill = m[s][w].v && !m[s][w].g && m[s][w].asid == iINV_ASID;
                        2'd2: kill = m[s][w].v && !m[s][w].g;
                        default: kill = 1'b1;
                    endcase
                    if (kill) begin
                        m[s][w].v = 1'b0;
                        m[s][w].age = WAYS - 1;
                    end
                end
        end else begin
            if (iWR_REQ) begin
                wvpn = iWR_VADDR >> PS;
                ws   = int'(wvpn % SETS);
                ww   = m_find(ws, wvpn, iWR_ASID);
                for (int w = WAYS - 1; w >= 0 && ww < 0; w--) begin end
                if (ww < 0)
                    for (int w = 0; w < WAYS && ww < 0; w++) if (!m[ws][w].v) ww = w;
                if (ww < 0)
                    for (int w = 0; w < WAYS && ww < 0; w++)
                        if (m[ws][w].age == WAYS - 1) ww = w;
                if (ww < 0) ww = 0;
                m_touch(ws, ww);
                m[ws][ww].v = 1'b1;   m[ws][ww].vpn = wvpn; m[ws][ww].asid = iWR_ASID;
                m[ws][ww].g = iWR_GLOBAL; m[ws][ww].ppn = iWR_PPN; m[ws][ww].fl = iWR_FLAGS;
            end else begin
                ws = -1;
            end
            if (iRD_REQ && rw >= 0 && !(iWR_REQ && ws == rs)) m_touch(rs, rw);
        end
    endtask

    task automatic do_reset();
        idle();
        inRESET = 1'b0;
        #3;
        @(negedge iCLOCK);
        inRESET = 1'b1;
    endtask

    initial begin
        logic [47:0] exp;
        vec_t mix;
        int unsigned vpn;

        idle();
        #12;
        check("reset_outputs", outs(), 48'h0);
        @(negedge iCLOCK);
        inRESET = 1'b1;

        tbl.push_back(v_rd(32'h0000_4000, 8'd1, 1'b0, 14'h0, 32'h0));
        // Basic hit/miss, then global overwrite in place
        tbl.push_back(v_wr(32'h1234_C000, 8'd3, 1'b0, 18'h2AAAA, 14'h155));
        tbl.push_back(v_rd(32'h1234_C123, 8'd3, 1'b1, 14'h155, 32'hAAAA_8123));
        tbl.push_back(v_rd(32'h1234_C123, 8'd4, 1'b0, 14'h0, 32'h0));
        tbl.push_back(v_wr(32'h1234_C000, 8'd3, 1'b1, 18'h15555, 14'h0AA));
        tbl.push_back(v_rd(32'h1234_C123, 8'd4, 1'b1, 14'h0AA, 32'h5555_4123));
        tbl.push_back(v_rd(32'h1234_C123, 8'd3, 1'b1, 14'h0AA, 32'h5555_4123));
        // LRU replacement in set 0: A..D, hit A, E evicts B, F evicts C
        for (int i = 0; i < 4; i++)
            tbl.push_back(v_wr(32'(i + 1) << 16, 8'd5, 1'b0, 18'(16 + i), 14'(i + 1)));
        tbl.push_back(v_rd(32'h0001_0000, 8'd5, 1'b1, 14'd1, 32'h0004_0000));
        tbl.push_back(v_wr(32'h0005_0000, 8'd5, 1'b0, 18'h14, 14'd5));
        tbl.push_back(v_wr(32'h0006_0000, 8'd5, 1'b0, 18'h15, 14'd6));
        tbl.push_back(v_rd(32'h0002_0000, 8'd5, 1'b0, 14'h0, 32'h0));
        tbl.push_back(v_rd(32'h0003_0000, 8'd5, 1'b0, 14'h0, 32'h0));
        tbl.push_back(v_rd(32'h0001_0000, 8'd5, 1'b1, 14'd1, 32'h0004_0000));
        tbl.push_back(v_rd(32'h0004_0000, 8'd5, 1'b1, 14'd4, 32'h0004_C000));
        tbl.push_back(v_rd(32'h0005_0000, 8'd5, 1'b1, 14'd5, 32'h0005_0000));
        tbl.push_back(v_rd(32'h0006_0000, 8'd5, 1'b1, 14'd6, 32'h0005_4000));
        // Invalidate modes in set 2
        tbl.push_back(v_wr(32'h0010_8000, 8'd1, 1'b0, 18'h21, 14'h11));
        tbl.push_back(v_wr(32'h0020_8000, 8'd2, 1'b0, 18'h22, 14'h12));
        tbl.push_back(v_wr(32'h0030_8000, 8'd1, 1'b1, 18'h23, 14'h13));
        tbl.push_back(v_inv(2'd1, 32'h0, 8'd1));
        tbl.push_back(v_rd(32'h0010_8000, 8'd1, 1'b0, 14'h0, 32'h0));
        tbl.push_back(v_rd(32'h0020_8000, 8'd2, 1'b1, 14'h12, 32'h0008_8000));
        tbl.push_back(v_rd(32'h0030_8000, 8'd1, 1'b1, 14'h13, 32'h0008_C000));
        tbl.push_back(v_inv(2'd2, 32'h0, 8'd0));
        tbl.push_back(v_rd(32'h0020_8000, 8'd2, 1'b0, 14'h0, 32'h0));
        tbl.push_back(v_rd(32'h0030_8000, 8'd7, 1'b1, 14'h13, 32'h0008_C000));
        tbl.push_back(v_inv(2'd3, 32'h0, 8'd0));
        tbl.push_back(v_rd(32'h0030_8000, 8'd1, 1'b0, 14'h0, 32'h0));
        tbl.push_back(v_rd(32'h0001_0000, 8'd5, 1'b0, 14'h0, 32'h0));
        tbl.push_back(v_wr(32'h0010_8000, 8'd1, 1'b0, 18'h21, 14'h11));
        tbl.push_back(v_wr(32'h0040_8000, 8'd1, 1'b0, 18'h24, 14'h14));
        tbl.push_back(v_inv(2'd0, 32'h0010_8000, 8'd1));
        tbl.push_back(v_rd(32'h0010_8000, 8'd1, 1'b0, 14'h0, 32'h0));
        tbl.push_back(v_rd(32'h0040_8000, 8'd1, 1'b1, 14'h14, 32'h0009_0000));
        // Lookup + refill + invalidate on set 1 in the same cycle
        tbl.push_back(v_wr(32'h0010_4000, 8'd1, 1'b0, 18'h31, 14'h21));
        tbl.push_back(v_wr(32'h0020_4000, 8'd1, 1'b0, 18'h32, 14'h22));
        mix = v_rd(32'h0020_4abc, 8'd1, 1'b1, 14'h22, 32'h000C_8abc);
        mix.wr = 1'b1; mix.wva = 32'h0030_4000; mix.was = 8'd1; mix.ppn = 18'h33;
        mix.wfl = 14'h23;
        mix.inv = 1'b1; mix.im = 2'd0; mix.iva = 32'h0020_4000; mix.ias = 8'd1;
        tbl.push_back(mix);
        tbl.push_back(v_rd(32'h0020_4000, 8'd1, 1'b0, 14'h0, 32'h0));
        tbl.push_back(v_rd(32'h0030_4000, 8'd1, 1'b0, 14'h0, 32'h0));
        tbl.push_back(v_rd(32'h0010_4000, 8'd1, 1'b1, 14'h21, 32'h000C_4000));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(posedge iCLOCK);
            #1;
            check($sformatf("vec%0d", i), outs(), {tbl[i].ev, tbl[i].eh, tbl[i].ef, tbl[i].ep});
        end

        do_reset();
        m_reset();
        for (int i = 0; i < 3000; i++) begin
            vpn = $urandom_range(4, 19);
            iRD_REQ   = ($urandom_range(0, 9) < 7);
            iRD_VADDR = (vpn << PS) | $urandom_range(0, 16383);
            iRD_ASID  = 8'($urandom_range(1, 3));
            vpn = $urandom_range(4, 19);
            iWR_REQ    = ($urandom_range(0, 9) < 4);
            iWR_VADDR  = (vpn << PS) | $urandom_range(0, 16383);
            iWR_ASID   = 8'($urandom_range(1, 3));
            iWR_GLOBAL = ($urandom_range(0, 4) == 0);
            iWR_PPN    = 18'($urandom);
            iWR_FLAGS  = 14'($urandom);
            vpn = $urandom_range(4, 19);
            iINV_REQ   = ($urandom_range(0, 24) == 0);
            iINV_MODE  = 2'($urandom_range(0, 3));
            iINV_VADDR = vpn << PS;
            iINV_ASID  = 8'($urandom_range(1, 3));
            m_step(exp);
            @(posedge iCLOCK);
            #1;
            check($sformatf("rand%0d", i), outs(), exp);
        end

        // Asynchronous reset while a hit result is being presented
        idle();
        drive(v_wr(32'h0070_4000, 8'd1, 1'b0, 18'h77, 14'h7));
        @(posedge iCLOCK);
        #1;
        drive(v_rd(32'h0070_4010, 8'd1, 1'b0, 14'h0, 32'h0));
        @(posedge iCLOCK);
        #1;
        check("pre_reset_hit", outs(), {1'b1, 1'b1, 14'h7, 32'h001D_C010});
        #2;
        inRESET = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 48'h0);
        idle();
        @(negedge iCLOCK);
        inRESET = 1'b1;
        drive(v_rd(32'h0070_4010, 8'd1, 1'b0, 14'h0, 32'h0));
        @(posedge iCLOCK);
        #1;
        check("post_reset_miss", outs(), {1'b1, 47'h0});
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
